llbit_wb_commit: RTL

// - Writeback-side owner of the MIPS LLbit. It sits directly downstream of the LLbit OITF tracker.
// - Buffers LLbit write requests leaving MEM in a small skid FIFO and commits them in order into the LLbit register.
// - Raises wreg_wb once per committed write so the tracker retires its entry.
// - Serves LLbit reads for SC/MFC0 with same-cycle commit bypass.

---
 rtl/llbit_wb_commit_pkg.sv | 21 ++
 rtl/llbit_skid_fifo.sv | 68 ++++++
 rtl/llbit_wb_commit.sv | 129 ++++++++++++
 3 files changed

// File: rtl/llbit_wb_commit_pkg.sv
// Shared types and defaults for the writeback-side LLbit owner.
package llbit_wb_commit_pkg;

  // Default skid FIFO depth (power of two, at least 2).
  localparam int unsigned LLBIT_SKID_DEPTH = 2;
  // Default width of the saturating LL-set event counter.
  localparam int unsigned LLBIT_CNT_W      = 16;

  // One buffered LLbit write request leaving MEM.
  typedef struct packed {
    logic we;      // request writes the LLbit
    logic wdata;   // value to write
    logic killed;  // a flush has hit this entry; it may only write 0
  } llbit_entry_t;

  // Value an entry commits into the LLbit: killed entries always clear it.
  function automatic logic entry_cval(input llbit_entry_t e);
    return e.killed ? 1'b0 : e.wdata;
  endfunction

endpackage

// File: rtl/llbit_skid_fifo.sv
// Skid FIFO of LLbit write requests. Holds the entry array, the
// allocate/retire pointers and full/empty, and marks every resident
// entry killed when a flush is sampled.
module llbit_skid_fifo
  import llbit_wb_commit_pkg::*;
#(
  parameter int unsigned DEPTH = LLBIT_SKID_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  llbit_entry_t i_push_entry,
  input  logic         i_pop,
  input  logic         i_flush,
  output llbit_entry_t o_head,
  output logic         o_full,
  output logic         o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [AW:0]  r_alc_ptr;
  logic [AW:0]  r_ret_ptr;
  llbit_entry_t r_mem [DEPTH];

  // Advance the allocate pointer on push and the retire pointer on pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_alc_ptr <= '0;
      r_ret_ptr <= '0;
    end else begin
      if (i_push) begin
        r_alc_ptr <= r_alc_ptr + (AW+1)'(1);
      end
      if (i_pop) begin
        r_ret_ptr <= r_ret_ptr + (AW+1)'(1);
      end
    end
  end

  // Entry storage: flush kills all residents; a push in the same cycle
  // lands already killed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (i_flush) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          r_mem[i].killed <= 1'b1;
        end
      end
      if (i_push) begin
        r_mem[r_alc_ptr[AW-1:0]] <= '{we:     i_push_entry.we,
                                       wdata:  i_push_entry.wdata,
                                       killed: i_push_entry.killed | i_flush};
      end
    end
  end

  assign o_head  = r_mem[r_ret_ptr[AW-1:0]];
  assign o_empty = (r_alc_ptr == r_ret_ptr);
  assign o_full  = (r_alc_ptr[AW] != r_ret_ptr[AW]) &&
                   (r_alc_ptr[AW-1:0] == r_ret_ptr[AW-1:0]);

endmodule

// File: rtl/llbit_wb_commit.sv
// Writeback-side owner of the MIPS LLbit. Buffers LLbit writes from MEM,
// commits them in order, pulses the OITF retire strobe per committed
// write, and serves LLbit reads with a same-cycle commit bypass.
module llbit_wb_commit
  import llbit_wb_commit_pkg::*;
#(
  parameter int unsigned SKID_DEPTH = LLBIT_SKID_DEPTH,
  parameter int unsigned CNT_W      = LLBIT_CNT_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        mem_valid,
  output logic                        mem_ready,
  input  logic                        mem_llbit_we,
  input  logic                        mem_llbit_wdata,
  input  logic                        wb_stall,
  input  logic                        flush,
  input  logic                        llbit_rd_en,
  output logic                        llbit_rdata,
  output logic                        llbit_r,
  output logic                        wreg_wb,
  output logic [$clog2(SKID_DEPTH):0] pending_we,
  output logic [CNT_W-1:0]            ll_set_cnt
);

  localparam int unsigned PW = $clog2(SKID_DEPTH) + 1;

  logic         w_full;
  logic         w_empty;
  logic         w_push;
  logic         w_commit;
  logic         w_commit_we;
  logic         w_cval;
  llbit_entry_t w_head;
  llbit_entry_t w_push_entry;

  logic          r_llbit;
  logic          w_llbit_nxt;
  logic [PW-1:0] r_pending_we;
  logic [PW-1:0] w_pending_nxt;
  logic [CNT_W-1:0] r_ll_set_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic          w_rdata;

  // No pass-through: a full FIFO stays not-ready even in a cycle it pops.
  assign mem_ready    = rst_n & ~w_full;
  assign w_push       = mem_valid & mem_ready;
  assign w_push_entry = '{we: mem_llbit_we, wdata: mem_llbit_wdata, killed: flush};

  // Gating with rst_n keeps discarded entries from pulsing the OITF.
  assign w_commit    = rst_n & ~w_empty & ~wb_stall;
  assign w_cval      = entry_cval(w_head);
  assign w_commit_we = w_commit & w_head.we;

  llbit_skid_fifo #(
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_commit),
    .i_flush      (flush),
    .o_head       (w_head),
    .o_full       (w_full),
    .o_empty      (w_empty)
  );

  // Next LLbit: flush wins over any same-cycle commit.
  always_comb begin
    w_llbit_nxt = r_llbit;
    if (flush) begin
      w_llbit_nxt = 1'b0;
    end else if (w_commit_we) begin
      w_llbit_nxt = w_cval;
    end else begin
      w_llbit_nxt = r_llbit;
    end
  end

  // Resident we=1 count, adjusted by both a push and a pop in one cycle.
  always_comb begin
    w_pending_nxt = r_pending_we
                  + PW'(w_push & mem_llbit_we)
                  - PW'(w_commit_we);
  end

  // Saturating count of commits that set the LLbit.
  always_comb begin
    w_cnt_nxt = r_ll_set_cnt;
    if (w_commit_we && w_cval && (r_ll_set_cnt != {CNT_W{1'b1}})) begin
      w_cnt_nxt = r_ll_set_cnt + CNT_W'(1);
    end else begin
      w_cnt_nxt = r_ll_set_cnt;
    end
  end

  // Read mux: a same-cycle commit is forwarded ahead of the register.
  always_comb begin
    w_rdata = 1'b0;
    if (!rst_n || !llbit_rd_en) begin
      w_rdata = 1'b0;
    end else if (w_commit_we) begin
      w_rdata = w_cval;
    end else begin
      w_rdata = r_llbit;
    end
  end

  // Architectural state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_llbit      <= 1'b0;
      r_pending_we <= '0;
      r_ll_set_cnt <= '0;
    end else begin
      r_llbit      <= w_llbit_nxt;
      r_pending_we <= w_pending_nxt;
      r_ll_set_cnt <= w_cnt_nxt;
    end
  end

  assign llbit_r     = r_llbit;
  assign pending_we  = r_pending_we;
  assign ll_set_cnt  = r_ll_set_cnt;
  assign wreg_wb     = w_commit_we;
  assign llbit_rdata = w_rdata;

endmodule
